// File: rtl/inst_mem_loader_if.sv
// Load-stream and fetch-port bundle for inst_mem_loader.
// INST_MEM_PARITY_EN adds perr_inject and fetch_perr.
interface inst_mem_loader_if #(
  parameter int A = 12,
  parameter int W = 9
);
  logic         load_start;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         load_last;
  logic         load_done;
  logic [A:0]   prog_len;
  logic         fetch_req;
  logic [A-1:0] fetch_addr;
  logic         fetch_valid;
  logic [W-1:0] fetch_data;
  logic         fetch_oob;
  logic         busy;
`ifdef INST_MEM_PARITY_EN
  logic         perr_inject;
  logic         fetch_perr;
`endif

  modport master (
`ifdef INST_MEM_PARITY_EN
    output perr_inject,
    input  fetch_perr,
`endif
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, load_done, prog_len, fetch_valid, fetch_data, fetch_oob, busy
  );

  modport slave (
`ifdef INST_MEM_PARITY_EN
    input  perr_inject,
    output fetch_perr,
`endif
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, load_done, prog_len, fetch_valid, fetch_data, fetch_oob, busy
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Run-time loadable instruction store with single-cycle fetch and HALT on out-of-range.
// Optional per-word even parity is enabled with INST_MEM_PARITY_EN.
//
// state   | meaning
// S_EMPTY | no program present, fetches ignored
// S_LOAD  | accepting load words, fetches ignored
// S_READY | program present, serving fetches
module inst_mem_loader #(
  parameter int             A         = 12,
  parameter int             W         = 9,
  parameter int             DEPTH     = 2**A,
  parameter logic [W-1:0]   HALT_WORD = {W{1'b1}}
) (
  input logic             clk,
  input logic             rst_n,
  inst_mem_loader_if.slave bus
);

`ifdef INST_MEM_PARITY_EN
  localparam int SW = W + 1;
`else
  localparam int SW = W;
`endif
  localparam logic [A:0] DEPTH_L = (A+1)'(DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

  state_t        state, state_nx;
  logic [A:0]    wr_ptr, wr_ptr_inc, prog_len;
  logic          wr_en, complete, restart, fetch_go, addr_oob;
  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] wr_word, rd_word;

  assign wr_ptr_inc = wr_ptr + (A+1)'(1);
  assign addr_oob   = ({1'b0, bus.fetch_addr} >= prog_len);
  assign rd_word    = mem[bus.fetch_addr];

`ifdef INST_MEM_PARITY_EN
  assign wr_word = {(^bus.load_data) ^ bus.perr_inject, bus.load_data};
`else
  assign wr_word = bus.load_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nx;
  end

  // load_start outranks both a load word and a fetch arriving in the same cycle
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    complete = 1'b0;
    restart  = 1'b0;
    fetch_go = 1'b0;
    case (state)
      S_EMPTY: begin
        if (bus.load_start) begin
          state_nx = S_LOAD;
          restart  = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.load_start) begin
          restart = 1'b1;
        end else if (bus.load_valid) begin
          wr_en = 1'b1;
          if (bus.load_last || (wr_ptr_inc == DEPTH_L)) begin
            complete = 1'b1;
            state_nx = S_READY;
          end
        end
      end
      S_READY: begin
        if (bus.load_start) begin
          state_nx = S_LOAD;
          restart  = 1'b1;
        end else begin
          fetch_go = bus.fetch_req;
        end
      end
      default: state_nx = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[A-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      prog_len        <= '0;
      bus.load_done   <= 1'b0;
      bus.fetch_valid <= 1'b0;
      bus.fetch_oob   <= 1'b0;
      bus.fetch_data  <= HALT_WORD;
    end else begin
      if (restart) begin
        wr_ptr   <= '0;
        prog_len <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (complete) prog_len <= wr_ptr_inc;
      bus.load_done   <= complete;
      bus.fetch_valid <= fetch_go;
      bus.fetch_oob   <= fetch_go & addr_oob;
      if (fetch_go) bus.fetch_data <= addr_oob ? HALT_WORD : rd_word[W-1:0];
    end
  end

`ifdef INST_MEM_PARITY_EN
  // stored word plus parity bit XORs to zero when intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.fetch_perr <= 1'b0;
    else        bus.fetch_perr <= fetch_go & ~addr_oob & (^rd_word);
  end
`endif

  assign bus.load_ready = (state == S_LOAD);
  assign bus.busy       = (state == S_LOAD);
  assign bus.prog_len   = prog_len;

endmodule
